// File: rtl/psr_cond_unit_pkg.sv
// Shared ALU definitions: function codes, PSR flag positions and branch condition codes.
// Used by the ALU, the PSR/condition unit and the branch unit.
package psr_cond_unit_pkg;

  localparam int FLAG_W = 5;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_LSH = 3'b110,
    ALU_ASH = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,  // Z
    COND_NE = 4'h1,  // !Z
    COND_CS = 4'h2,  // C
    COND_CC = 4'h3,  // !C
    COND_LT = 4'h4,  // L
    COND_GE = 4'h5,  // !L
    COND_MI = 4'h6,  // N
    COND_PL = 4'h7,  // !N
    COND_FS = 4'h8,  // F
    COND_FC = 4'h9,  // !F
    COND_GT = 4'hA,  // !L & !Z
    COND_LE = 4'hB,  // L | Z
    COND_HI = 4'hC,  // !N & !Z
    COND_LS = 4'hD,  // N | Z
    COND_AL = 4'hE,  // always
    COND_NV = 4'hF   // never
  } cond_e;

  // Which PSR bits an ALU op is allowed to overwrite; the rest keep their old value.
  function automatic logic [FLAG_W-1:0] flag_mask(input alu_op_e op);
    logic [FLAG_W-1:0] m;
    m = '0;
    case (op)
      ALU_SUB: begin
        m[FLAG_C] = 1'b1;
        m[FLAG_L] = 1'b1;
        m[FLAG_F] = 1'b1;
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      ALU_ADD: begin
        m[FLAG_C] = 1'b1;
        m[FLAG_F] = 1'b1;
        m[FLAG_Z] = 1'b1;
      end
      ALU_AND, ALU_OR, ALU_XOR, ALU_NOT: m[FLAG_Z] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/psr_cond_unit_cond_eval.sv
// Pure combinational branch-condition decode of a PSR value; shared with the branch unit.
module cond_eval
  import psr_cond_unit_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] psr,
  output logic              taken
);

  logic c_f, l_f, f_f, z_f, n_f;

  assign c_f = psr[FLAG_C];
  assign l_f = psr[FLAG_L];
  assign f_f = psr[FLAG_F];
  assign z_f = psr[FLAG_Z];
  assign n_f = psr[FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = z_f;
      COND_NE: taken = ~z_f;
      COND_CS: taken = c_f;
      COND_CC: taken = ~c_f;
      COND_LT: taken = l_f;
      COND_GE: taken = ~l_f;
      COND_MI: taken = n_f;
      COND_PL: taken = ~n_f;
      COND_FS: taken = f_f;
      COND_FC: taken = ~f_f;
      COND_GT: taken = ~l_f & ~z_f;
      COND_LE: taken = l_f | z_f;
      COND_HI: taken = ~n_f & ~z_f;
      COND_LS: taken = n_f | z_f;
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond_unit.sv
// Processor status register with flag capture, direct load, interrupt save/restore stack
// and registered branch-condition evaluation against the PSR value being written this cycle.
module psr_cond_unit
  import psr_cond_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flag_we,
  input  logic [2:0]                     alu_sel,
  input  logic [FLAG_W-1:0]              flags_in,
  input  logic                           psr_wr,
  input  logic [FLAG_W-1:0]              psr_din,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           cond_valid,
  input  logic [3:0]                     cond,
  output logic [FLAG_W-1:0]              psr,
  output logic                           taken_valid,
  output logic                           taken,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           stack_err
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int DW = PW + 1;

  logic [FLAG_W-1:0] slots [STACK_DEPTH];

  logic [FLAG_W-1:0] upd_mask;
  logic [FLAG_W-1:0] flag_merge;
  logic [FLAG_W-1:0] top_slot;
  logic [FLAG_W-1:0] psr_next;
  logic [DW-1:0]     depth_dec;
  logic              full;
  logic              empty;
  logic              push_ok;
  logic              pop_ok;
  logic              err_event;
  logic              taken_next;

  assign upd_mask   = flag_mask(alu_op_e'(alu_sel));
  assign flag_merge = (flags_in & upd_mask) | (psr & ~upd_mask);

  assign full      = (depth == DW'(STACK_DEPTH));
  assign empty     = (depth == '0);
  assign depth_dec = depth - DW'(1);
  assign top_slot  = slots[depth_dec[PW-1:0]];

  // A push together with a pop is a conflict: neither side acts.
  assign push_ok   = push & ~pop & ~full;
  assign pop_ok    = pop & ~push & ~empty;
  assign err_event = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

  // Only a pop that actually restores outranks the other writers.
  always_comb begin
    psr_next = psr;
    if (pop_ok) begin
      psr_next = top_slot;
    end else if (psr_wr) begin
      psr_next = psr_din;
    end else if (flag_we) begin
      psr_next = flag_merge;
    end
  end

  cond_eval u_cond_eval (
    .cond  (cond),
    .psr   (psr_next),
    .taken (taken_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr         <= '0;
      depth       <= '0;
      taken_valid <= 1'b0;
      taken       <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      psr         <= psr_next;
      taken_valid <= cond_valid;
      taken       <= cond_valid & taken_next;
      if (push_ok) begin
        depth <= depth + DW'(1);
      end else if (pop_ok) begin
        depth <= depth_dec;
      end
      if (err_event) begin
        stack_err <= 1'b1;
      end
    end
  end

  // Slot storage needs no reset; a slot is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      slots[depth[PW-1:0]] <= psr_next;
    end
  end

endmodule
